// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit concentrator and the receive-side demux.
// Contents: FSM state type, data-bit count, and the 2-bit channel select encoding
// driven on {sel_a, sel_b} (sel_a is the MSB).
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   localparam logic [1:0] CH_A = 2'b00;
   localparam logic [1:0] CH_B = 2'b01;
   localparam logic [1:0] CH_C = 2'b10;
   localparam logic [1:0] CH_D = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } tx_state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter, purely combinational.
// Ports:
//   req     in  4  request per channel (bit 0 = A)
//   last    in  2  index of the most recently granted channel
//   gnt     out 4  one-hot grant, zero when no request
//   gnt_idx out 2  index of the granted channel (0 when no request)
// Search starts at last+1 and wraps 3 -> 0, so the last winner has lowest priority.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx
);

   logic       found;
   logic [1:0] idx;

   always_comb begin
      gnt     = 4'b0000;
      gnt_idx = 2'b00;
      found   = 1'b0;
      idx     = 2'b00;
      for (int i = 1; i <= 4; i++) begin
         // 2-bit add wraps naturally, so i = 4 revisits the last winner.
         idx = last + 2'(i);
         if (!found && req[idx]) begin
            found      = 1'b1;
            gnt[idx]   = 1'b1;
            gnt_idx    = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_mux4.sv
// Four-channel UART transmit concentrator: round-robin selects one of four byte
// channels and sends it as an 8N1 frame on a single serial line.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid[3:0]     per-channel byte valid (bit 0 = A .. bit 3 = D)
//   in_data[31:0]     channel bytes, [7:0] = A .. [31:24] = D
//   in_ready[3:0]     one-hot accept strobe, only in IDLE, combinational
//   tx                serial line, idle high
//   sel_a, sel_b      channel index of the current/last frame (sel_a = MSB)
//   busy              high from start bit through stop bit
//   done              one-cycle pulse on the last cycle of the stop bit
module uart_tx_mux4
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  in_valid,
   input  logic [31:0] in_data,
   output logic [3:0]  in_ready,
   output logic        tx,
   output logic        sel_a,
   output logic        sel_b,
   output logic        busy,
   output logic        done
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   // done is registered, so it is raised one cycle before the final stop cycle.
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

   tx_state_t                 state;
   logic [CNT_W-1:0]          bitCnt;
   logic [2:0]                bitIdx;
   logic [UART_DATA_BITS-1:0] shiftReg;
   logic [1:0]                lastGnt;
   logic [1:0]                selIdx;
   logic                      txReg;
   logic                      busyReg;
   logic                      doneReg;

   logic [3:0]                gnt;
   logic [1:0]                gntIdx;
   logic [7:0]                grantByte;
   logic                      bitEnd;

   rr_arbiter4 uArb (
      .req     (in_valid),
      .last    (lastGnt),
      .gnt     (gnt),
      .gnt_idx (gntIdx)
   );

   always_comb begin
      in_ready  = (state == StIdle) ? gnt : 4'b0000;
      grantByte = in_data[{gntIdx, 3'b000} +: 8];
      bitEnd    = (bitCnt == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         bitCnt   <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         lastGnt  <= CH_D;
         selIdx   <= CH_A;
         txReg    <= 1'b1;
         busyReg  <= 1'b0;
         doneReg  <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         unique case (state)
            StIdle: begin
               txReg   <= 1'b1;
               busyReg <= 1'b0;
               bitCnt  <= '0;
               bitIdx  <= '0;
               if (|gnt) begin
                  shiftReg <= grantByte;
                  selIdx   <= gntIdx;
                  lastGnt  <= gntIdx;
                  txReg    <= 1'b0;
                  busyReg  <= 1'b1;
                  state    <= StStart;
               end
            end
            StStart: begin
               if (bitEnd) begin
                  bitCnt <= '0;
                  txReg  <= shiftReg[0];
                  state  <= StData;
               end else begin
                  bitCnt <= bitCnt + 1'b1;
               end
            end
            StData: begin
               if (bitEnd) begin
                  bitCnt <= '0;
                  if (bitIdx == IDX_LAST) begin
                     txReg <= 1'b1;
                     state <= StStop;
                  end else begin
                     bitIdx   <= bitIdx + 3'd1;
                     shiftReg <= shiftReg >> 1;
                     txReg    <= shiftReg[1];
                  end
               end else begin
                  bitCnt <= bitCnt + 1'b1;
               end
            end
            StStop: begin
               if (bitEnd) begin
                  bitCnt  <= '0;
                  bitIdx  <= '0;
                  busyReg <= 1'b0;
                  state   <= StIdle;
               end else begin
                  bitCnt  <= bitCnt + 1'b1;
                  doneReg <= (bitCnt == CNT_PRE);
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign tx    = txReg;
   assign busy  = busyReg;
   assign done  = doneReg;
   assign sel_a = selIdx[1];
   assign sel_b = selIdx[0];

endmodule
